// File: rtl/cpu_reset_seq_if.sv
// cpu_reset_seq_if: reset request in, core reset/sequencing controls out
//   reset_n     external active-low reset request (async to clk)
//   core_rst    active-high reset to pipeline registers
//   stage_en    per-stage enable, bit0=IF .. bit4=WB
//   rf_clr_we   register-file clear strobe (write data is 0)
//   rf_clr_addr register-file clear address
//   pc_load     one-cycle PC load strobe
//   pc_value    PC value to load
//   ready       core fully running
interface cpu_reset_seq_if;
   logic        reset_n;
   logic        core_rst;
   logic [4:0]  stage_en;
   logic        rf_clr_we;
   logic [4:0]  rf_clr_addr;
   logic        pc_load;
   logic [31:0] pc_value;
   logic        ready;
   modport master (
      input  reset_n,
      output core_rst, stage_en, rf_clr_we, rf_clr_addr, pc_load, pc_value, ready
   );
   modport slave (
      output reset_n,
      input  core_rst, stage_en, rf_clr_we, rf_clr_addr, pc_load, pc_value, ready
   );
endinterface

// File: rtl/cpu_reset_seq.sv
// cpu_reset_seq: synchronizes/stretches reset_n, then clears RF, loads PC and ramps stage enables
//   clk   core clock, posedge
//   reset synchronous active-high power-on reset
//   bus   cpu_reset_seq_if.master (reset_n in; core_rst, stage_en, rf_clr_*, pc_*, ready out)
//   CPU_RESET_SEQ_RF_CLEAR_EN defined: register-file clear state present; undefined: rf_clr_* tied 0
module cpu_reset_seq #(
   parameter int          SYNC_STAGES = 2,
   parameter int          MIN_ASSERT  = 16,
   parameter int          NUM_REGS    = 32,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   cpu_reset_seq_if.master bus
);
   localparam int MX = MIN_ASSERT > NUM_REGS ? MIN_ASSERT : NUM_REGS;
   localparam int CW = MX > 4 ? $clog2(MX) : 2;
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
   typedef enum logic [2:0] {ASSERT, CLEAR, LOAD_PC, RELEASE, RUN} state_t;
`else
   typedef enum logic [2:0] {ASSERT, LOAD_PC, RELEASE, RUN} state_t;
`endif
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req;
   logic                   core_rst_q, pc_load_q, ready_q;
   logic [4:0]             stage_en_q;
   // sync flops reset to 0, so a request is pending straight out of reset
   assign req = ~sync_q[SYNC_STAGES-1];
   // counter restarts on every state change so it never wraps
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      if (req) begin
         state_d = ASSERT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ASSERT: if (cnt_q == CW'(MIN_ASSERT - 1)) begin
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
               state_d = CLEAR;
`else
               state_d = LOAD_PC;
`endif
               cnt_d   = '0;
            end
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
            CLEAR: if (cnt_q == CW'(NUM_REGS - 1)) begin
               state_d = LOAD_PC;
               cnt_d   = '0;
            end
`endif
            LOAD_PC: begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
            RELEASE: if (cnt_q == CW'(3)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
            RUN:     cnt_d = '0;
            default: begin
               state_d = ASSERT;
               cnt_d   = '0;
            end
         endcase
      end
   end
   // outputs are decoded from next state so they are registered without extra latency
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         state_q    <= ASSERT;
         cnt_q      <= '0;
         core_rst_q <= 1'b1;
         stage_en_q <= '0;
         pc_load_q  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.reset_n};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         core_rst_q <= !(state_d == RELEASE || state_d == RUN);
         stage_en_q <= state_d == RUN ? 5'h1f : state_d == RELEASE ? (5'd2 << cnt_d[1:0]) - 5'd1 : 5'h00;
         pc_load_q  <= state_d == LOAD_PC;
         ready_q    <= state_d == RUN;
      end
   end
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
   logic       rf_clr_we_q;
   logic [4:0] rf_clr_addr_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_clr_we_q   <= 1'b0;
         rf_clr_addr_q <= '0;
      end else begin
         rf_clr_we_q   <= state_d == CLEAR;
         rf_clr_addr_q <= state_d == CLEAR ? 5'(cnt_d) : 5'd0;
      end
   end
   assign bus.rf_clr_we   = rf_clr_we_q;
   assign bus.rf_clr_addr = rf_clr_addr_q;
`else
   assign bus.rf_clr_we   = 1'b0;
   assign bus.rf_clr_addr = 5'd0;
`endif
   assign bus.core_rst = core_rst_q;
   assign bus.stage_en = stage_en_q;
   assign bus.pc_load  = pc_load_q;
   assign bus.pc_value = RESET_PC;
   assign bus.ready    = ready_q;
endmodule

// File: tb/tb_cpu_reset_seq.sv
// tb_cpu_reset_seq: directed self-checking bench for cpu_reset_seq
module tb_cpu_reset_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   cpu_reset_seq_if bus();
   cpu_reset_seq dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
   localparam int RDY  = 55;
   localparam int NCLR = 32;
`else
   localparam int RDY  = 23;
   localparam int NCLR = 0;
`endif
   localparam int LD = RDY - 5;
   int errors = 0;
   int checks = 0;
   logic [4:0]  se_a [0:99];
   logic [4:0]  ad_a [0:99];
   logic        cr_a [0:99];
   logic        we_a [0:99];
   logic        pl_a [0:99];
   logic        rd_a [0:99];
   logic [31:0] pv_a [0:99];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // record outputs after edges 1..n; edge 1 is the first edge after this call
   task automatic capture(input int n);
      for (int e = 1; e <= n; e++) begin
         tick();
         se_a[e] = bus.stage_en;
         ad_a[e] = bus.rf_clr_addr;
         cr_a[e] = bus.core_rst;
         we_a[e] = bus.rf_clr_we;
         pl_a[e] = bus.pc_load;
         rd_a[e] = bus.ready;
         pv_a[e] = bus.pc_value;
      end
   endtask

   task automatic restart;
      bus.reset_n = 1'b0;
      repeat (4) tick();
      bus.reset_n = 1'b1;
      capture(70);
   endtask

   task automatic test_reset;
      logic [13:0] v;
      reset = 1'b1;
      bus.reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         v = {bus.core_rst, bus.stage_en, bus.rf_clr_we, bus.rf_clr_addr, bus.pc_load, bus.ready};
         checks++;
         if (v !== 14'h2000) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %h want %h", i, v, 14'h2000);
         end
         checks++;
         if (bus.pc_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc_value: got %h want %h", bus.pc_value, 32'h0);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_power_on;
      int npl;
      capture(70);
      npl = 0;
      for (int e = 1; e <= 70; e++) npl += int'(pl_a[e]);
      checks++;
      if (npl !== 1) begin
         errors++;
         $display("FAIL pc_load_count: got %0d want 1", npl);
      end
      checks++;
      if (pl_a[LD] !== 1'b1 || pv_a[LD] !== 32'h0) begin
         errors++;
         $display("FAIL pc_load_edge: got pl=%b pc=%h want pl=1 pc=0", pl_a[LD], pv_a[LD]);
      end
      checks++;
      if (rd_a[RDY] !== 1'b1 || rd_a[RDY-1] !== 1'b0) begin
         errors++;
         $display("FAIL ready_rise: got %b%b want 01", rd_a[RDY-1], rd_a[RDY]);
      end
      checks++;
      if (cr_a[2] !== 1'b1 || rd_a[2] !== 1'b0 || cr_a[LD] !== 1'b1) begin
         errors++;
         $display("FAIL early_core_rst: got %b%b%b want 101", cr_a[2], rd_a[2], cr_a[LD]);
      end
      checks++;
      if (rd_a[70] !== 1'b1 || cr_a[70] !== 1'b0 || se_a[70] !== 5'h1f) begin
         errors++;
         $display("FAIL run_hold: got rd=%b cr=%b se=%b want 1 0 11111", rd_a[70], cr_a[70], se_a[70]);
      end
   endtask

   task automatic test_clear_walk;
      int nwe;
      restart();
      nwe = 0;
      for (int e = 1; e <= 70; e++) nwe += int'(we_a[e]);
      checks++;
      if (nwe !== NCLR) begin
         errors++;
         $display("FAIL clear_count: got %0d want %0d", nwe, NCLR);
      end
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (we_a[18+i] !== 1'b1 || ad_a[18+i] !== 5'(i)) begin
            errors++;
            $display("FAIL clear_addr %0d: got we=%b addr=%0d want we=1 addr=%0d", i, we_a[18+i], ad_a[18+i], i);
         end
      end
      checks++;
      if (we_a[17] !== 1'b0 || we_a[50] !== 1'b0 || pl_a[50] !== 1'b1) begin
         errors++;
         $display("FAIL clear_bounds: got we17=%b we50=%b pl50=%b want 0 0 1", we_a[17], we_a[50], pl_a[50]);
      end
`endif
   endtask

   task automatic test_release_ramp;
      logic [4:0] ramp [5];
      ramp = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
      restart();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (se_a[RDY-4+i] !== ramp[i]) begin
            errors++;
            $display("FAIL ramp_step %0d: got %b want %b", i, se_a[RDY-4+i], ramp[i]);
         end
      end
      checks++;
      if (cr_a[RDY-5] !== 1'b1 || cr_a[RDY-4] !== 1'b0 || se_a[RDY-5] !== 5'h00) begin
         errors++;
         $display("FAIL ramp_core_rst: got %b%b se=%b want 10 00000", cr_a[RDY-5], cr_a[RDY-4], se_a[RDY-5]);
      end
      checks++;
      if (rd_a[RDY-1] !== 1'b0 || rd_a[RDY] !== 1'b1) begin
         errors++;
         $display("FAIL ramp_ready: got %b%b want 01", rd_a[RDY-1], rd_a[RDY]);
      end
   endtask

   task automatic test_stretch;
      bus.reset_n = 1'b0;
      tick();
      bus.reset_n = 1'b1;
      capture(70);
      checks++;
      if (rd_a[1] !== 1'b1 || rd_a[2] !== 1'b0 || cr_a[2] !== 1'b1) begin
         errors++;
         $display("FAIL stretch_abort: got rd1=%b rd2=%b cr2=%b want 1 0 1", rd_a[1], rd_a[2], cr_a[2]);
      end
      for (int e = 2; e <= 17; e++) begin
         checks++;
         if ({cr_a[e], we_a[e], pl_a[e], se_a[e]} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL stretch_assert edge %0d: got %b want 10000000", e, {cr_a[e], we_a[e], pl_a[e], se_a[e]});
         end
      end
      checks++;
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
      if (we_a[18] !== 1'b1) begin
         errors++;
         $display("FAIL stretch_exit: got we=%b want 1", we_a[18]);
      end
`else
      if (pl_a[18] !== 1'b1) begin
         errors++;
         $display("FAIL stretch_exit: got pl=%b want 1", pl_a[18]);
      end
`endif
      checks++;
      if (rd_a[RDY] !== 1'b1 || rd_a[RDY-1] !== 1'b0) begin
         errors++;
         $display("FAIL stretch_ready: got %b%b want 01", rd_a[RDY-1], rd_a[RDY]);
      end
   endtask

   task automatic test_abort;
      bit found;
`ifdef CPU_RESET_SEQ_RF_CLEAR_EN
      bus.reset_n = 1'b0;
      repeat (4) tick();
      bus.reset_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         found = bus.rf_clr_we === 1'b1 && bus.rf_clr_addr === 5'd10;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL abort_wait_addr10: got timeout want addr 10");
      end
      bus.reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.rf_clr_we !== 1'b1 || bus.rf_clr_addr !== 5'd12) begin
         errors++;
         $display("FAIL abort_latency: got we=%b addr=%0d want we=1 addr=12", bus.rf_clr_we, bus.rf_clr_addr);
      end
      tick();
      checks++;
      if ({bus.rf_clr_we, bus.core_rst, bus.stage_en} !== 7'b01_00000) begin
         errors++;
         $display("FAIL abort_clear: got %b want 0100000", {bus.rf_clr_we, bus.core_rst, bus.stage_en});
      end
      bus.reset_n = 1'b1;
      capture(70);
      checks++;
      if (we_a[17] !== 1'b0 || we_a[18] !== 1'b1 || ad_a[18] !== 5'd0 || rd_a[RDY] !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart: got we17=%b we18=%b addr=%0d rd=%b want 0 1 0 1", we_a[17], we_a[18], ad_a[18], rd_a[RDY]);
      end
`endif
      bus.reset_n = 1'b0;
      repeat (4) tick();
      bus.reset_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         found = bus.stage_en === 5'b00011;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL abort_wait_ramp: got timeout want stage_en 00011");
      end
      bus.reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.stage_en !== 5'b01111 || bus.core_rst !== 1'b0) begin
         errors++;
         $display("FAIL abort_ramp_latency: got se=%b cr=%b want 01111 0", bus.stage_en, bus.core_rst);
      end
      tick();
      checks++;
      if ({bus.core_rst, bus.ready, bus.stage_en} !== 7'b10_00000) begin
         errors++;
         $display("FAIL abort_ramp_wins: got %b want 1000000", {bus.core_rst, bus.ready, bus.stage_en});
      end
      bus.reset_n = 1'b1;
      capture(70);
      checks++;
      if (rd_a[RDY] !== 1'b1 || rd_a[RDY-1] !== 1'b0) begin
         errors++;
         $display("FAIL abort_ramp_recover: got %b%b want 01", rd_a[RDY-1], rd_a[RDY]);
      end
   endtask

   initial begin
      bus.reset_n = 1'b1;
      test_reset();
      test_power_on();
      test_clear_walk();
      test_release_ramp();
      test_stretch();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
